// File: rtl/pulse_interval_meter.sv
// Measures the clk-cycle interval between a start edge and the following stop edge,
// holding each result until the consumer accepts it and aborting after TIMEOUT_CYC cycles.
module pulse_interval_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start_in,
    input  logic             stop_in,
    output logic [CNT_W-1:0] result_data,
    output logic             result_timeout,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic [7:0]       missed_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        MEASURE    = 2'd2,
        HOLD       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    state_t           state, state_nxt;
    logic             start_prev, stop_prev;
    logic             start_edge, stop_edge;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] data_nxt;
    logic             timeout_nxt;
    logic [7:0]       missed_nxt;

    assign start_edge = start_in & ~start_prev;
    assign stop_edge  = stop_in  & ~stop_prev;

    // Outputs are pure decodes of registered state, so no input reaches them combinationally.
    assign result_valid = (state == HOLD);
    assign busy         = (state == MEASURE) || (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            start_prev     <= 1'b1;
            stop_prev      <= 1'b1;
            cnt            <= '0;
            result_data    <= '0;
            result_timeout <= 1'b0;
            missed_count   <= 8'd0;
        end else begin
            state          <= state_nxt;
            start_prev     <= start_in;
            stop_prev      <= stop_in;
            cnt            <= cnt_nxt;
            result_data    <= data_nxt;
            result_timeout <= timeout_nxt;
            missed_count   <= missed_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        data_nxt    = result_data;
        timeout_nxt = result_timeout;
        missed_nxt  = missed_count;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (start_edge && stop_edge) begin
                    data_nxt    = '0;
                    timeout_nxt = 1'b0;
                    state_nxt   = HOLD;
                end else if (start_edge) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // A stop landing on the timeout cycle is still reported as a real stop.
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (stop_edge) begin
                    data_nxt    = cnt;
                    timeout_nxt = 1'b0;
                    state_nxt   = HOLD;
                end else if (cnt == TIMEOUT_VAL) begin
                    data_nxt    = TIMEOUT_VAL;
                    timeout_nxt = 1'b1;
                    state_nxt   = HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                cnt_nxt = '0;
                if (start_edge && (missed_count != 8'hFF))
                    missed_nxt = missed_count + 8'd1;
                if (result_ready)
                    state_nxt = enable ? WAIT_START : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
